spi_frame_slave: RTL and testbench

Oversampled SPI slave (mode 0) that decodes command/address/data frames from the board controller. Each completed write word is presented as an address/data/valid strobe to the downstream dual-port RAM write port. For reads, the block drives an address to that RAM port and serializes the returned word onto SPI_SO. All logic runs on the fast SPI system clock; SPI pins are asynchronous inputs.

---
 rtl/spi_frame_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_spi_frame_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: oversampled SPI mode-0 slave decoding cmd/addr/data frames.
// A frame is an 8-bit command (bit 7: 1 = write, 0 = read), a 16-bit word
// address, then 32-bit data words. Writes appear as a one-clock
// SERIAL_valid strobe with SERIAL_addr/SERIAL_data. Reads drive SERIAL_addr
// to a RAM port and shift the returned word out on SPI_SO.
//
// Optional feature macro: SPI_FRAME_BURST_EN
//   defined   -> burst mode: address auto-increments after every data word
//                and the DATA state repeats until CS rises.
//   undefined -> single-word mode: one data word, then DONE until CS rises.
//
// o_dbg_state exposes the frame FSM state (IDLE=0, CMD=1, ADDR=2, DATA=3,
// DONE=4) for observation.
//
// Data-phase handshake: SERIAL_valid is a one-clock strobe with no
// back-pressure; SERIAL_addr and SERIAL_data are valid while it is high and
// stay stable until the next strobe (the burst increment lands the clock
// after the strobe). SPI_data_i is treated as valid READ_LAT clocks after
// SERIAL_addr changes.

module spi_frame_slave #(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SPI_CS,
    input  logic        SPI_CLK,
    input  logic        SPI_SI,
    output logic        SPI_SO,
    output logic [31:0] SERIAL_data,
    output logic [15:0] SERIAL_addr,
    output logic        SERIAL_valid,
    input  logic [31:0] SPI_data_i,
    output logic [2:0]  o_dbg_state
);

`ifdef SPI_FRAME_BURST_EN
    localparam logic LP_BURST = 1'b1;
`else
    localparam logic LP_BURST = 1'b0;
`endif

    localparam logic [2:0] LP_LAT = 3'(READ_LAT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Synchronizers and edge-detect history
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_si_s1, r_si_s2;

    // Frame decode state
    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_bit_cnt;
    logic        r_is_write;
    logic        r_started;
    logic [30:0] r_rx_sh;

    // Output registers
    logic [31:0] r_data;
    logic [15:0] r_addr;
    logic        r_valid;

    // Read path: TX shifter, prefetch buffer and RAM latency tracking
    logic [31:0] r_tx_sh;
    logic [31:0] r_pref;
    logic        r_fetch_pend;
    logic [2:0]  r_fetch_cnt;
    logic        r_fetch_to_tx;
    logic        r_inc_pend;

    // Decoded pulses from synchronized pins
    logic w_cs_high;
    logic w_cs_fall;
    logic w_rise;
    logic w_fall;
    logic w_si;

    assign w_cs_high = r_cs_s2;
    assign w_cs_fall = r_cs_s3 & ~r_cs_s2;
    assign w_rise    = r_sck_s2 & ~r_sck_s3;
    assign w_fall    = ~r_sck_s2 & r_sck_s3;
    assign w_si      = r_si_s2;

    // Pin synchronizers; left unreset so they keep tracking the pins during
    // reset and a CS already low at reset release is not seen as a new edge.
    always_ff @(posedge clk) begin
        r_cs_s1  <= SPI_CS;
        r_cs_s2  <= r_cs_s1;
        r_cs_s3  <= r_cs_s2;
        r_sck_s1 <= SPI_CLK;
        r_sck_s2 <= r_sck_s1;
        r_sck_s3 <= r_sck_s2;
        r_si_s1  <= SPI_SI;
        r_si_s2  <= r_si_s1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: CS high aborts from anywhere, otherwise bit counts advance phases
    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_high) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
                ST_CMD:  if (w_rise && (r_bit_cnt == 5'd7))  w_state_nxt = ST_ADDR;
                ST_ADDR: if (w_rise && (r_bit_cnt == 5'd15)) w_state_nxt = ST_DATA;
                ST_DATA: if (w_rise && (r_bit_cnt == 5'd31) && !LP_BURST) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath: bit counting, RX/TX shifting, strobes, address and RAM fetch sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt     <= 5'd0;
            r_is_write    <= 1'b0;
            r_started     <= 1'b0;
            r_rx_sh       <= 31'd0;
            r_data        <= 32'd0;
            r_addr        <= 16'd0;
            r_valid       <= 1'b0;
            r_tx_sh       <= 32'd0;
            r_pref        <= 32'd0;
            r_fetch_pend  <= 1'b0;
            r_fetch_cnt   <= 3'd0;
            r_fetch_to_tx <= 1'b0;
            r_inc_pend    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_cs_high || (r_state == ST_IDLE)) begin
                // Abort or idle: drop any partial word, keep the last address/data
                r_bit_cnt    <= 5'd0;
                r_started    <= 1'b0;
                r_rx_sh      <= 31'd0;
                r_tx_sh      <= 32'd0;
                r_fetch_pend <= 1'b0;
                r_inc_pend   <= 1'b0;
            end else begin
                // RAM latency countdown; the first word goes straight to TX,
                // burst prefetches park in r_pref until the word boundary.
                if (r_fetch_pend) begin
                    if (r_fetch_cnt <= 3'd1) begin
                        r_fetch_pend <= 1'b0;
                        if (r_fetch_to_tx) begin
                            r_tx_sh    <= SPI_data_i;
                            r_inc_pend <= LP_BURST;
                        end else begin
                            r_pref <= SPI_data_i;
                        end
                    end else begin
                        r_fetch_cnt <= r_fetch_cnt - 3'd1;
                    end
                end

                // Burst address step; on reads this also launches the prefetch
                if (r_inc_pend) begin
                    r_inc_pend <= 1'b0;
                    r_addr     <= r_addr + 16'd1;
                    if (!r_is_write) begin
                        r_fetch_pend  <= 1'b1;
                        r_fetch_cnt   <= LP_LAT;
                        r_fetch_to_tx <= 1'b0;
                    end
                end

                if (w_rise) begin
                    case (r_state)
                        ST_CMD: begin
                            if (r_bit_cnt == 5'd0) begin
                                r_is_write <= w_si;
                            end
                            r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                        end
                        ST_ADDR: begin
                            r_rx_sh <= {r_rx_sh[29:0], w_si};
                            if (r_bit_cnt == 5'd15) begin
                                r_bit_cnt <= 5'd0;
                                r_addr    <= {r_rx_sh[14:0], w_si};
                                if (!r_is_write) begin
                                    r_fetch_pend  <= 1'b1;
                                    r_fetch_cnt   <= LP_LAT;
                                    r_fetch_to_tx <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        ST_DATA: begin
                            r_rx_sh   <= {r_rx_sh[29:0], w_si};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_started <= 1'b1;
                            if ((r_bit_cnt == 5'd31) && r_is_write) begin
                                r_data     <= {r_rx_sh, w_si};
                                r_valid    <= 1'b1;
                                r_inc_pend <= LP_BURST;
                            end
                        end
                        default: begin
                        end
                    endcase
                end

                // Read TX: the fall after the last address bit presents bit 31
                // unshifted; afterwards each fall shifts, and a fall on a word
                // boundary swaps in the prefetched word instead.
                if (w_fall && (r_state == ST_DATA) && !r_is_write && r_started) begin
                    if (r_bit_cnt == 5'd0) begin
                        if (LP_BURST) begin
                            r_tx_sh    <= r_pref;
                            r_inc_pend <= 1'b1;
                        end
                    end else begin
                        r_tx_sh <= {r_tx_sh[30:0], 1'b0};
                    end
                end
            end
        end
    end

    assign SPI_SO       = ((r_state == ST_DATA) && !r_is_write) ? r_tx_sh[31] : 1'b0;
    assign SERIAL_data  = r_data;
    assign SERIAL_addr  = r_addr;
    assign SERIAL_valid = r_valid;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: randomized and directed SPI frames against a
// frame-level reference model. Expected write strobes and read words are
// queued when a frame is issued; monitors pop and compare as the DUT
// produces them. Honors SPI_FRAME_BURST_EN the same way the design does.

module tb_spi_frame_slave;

    localparam int READ_LAT = 2;
    localparam int LAT_IDX  = (READ_LAT >= 2) ? READ_LAT - 2 : 0;
    localparam int HALF     = 8;     // clk cycles per SCK half period (f_clk = 16 f_SCK)

`ifdef SPI_FRAME_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        SPI_CS;
    logic        SPI_CLK;
    logic        SPI_SI;
    logic        SPI_SO;
    logic [31:0] SERIAL_data;
    logic [15:0] SERIAL_addr;
    logic        SERIAL_valid;
    logic [31:0] SPI_data_i;
    logic [2:0]  o_dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_q[$];      // {addr, data} of expected write strobes
    logic [31:0] rd_exp_q[$];   // words the master should shift in
    logic [31:0] rd_obs_q[$];   // words the master did shift in
    logic [31:0] wdata [0:3];
    logic [15:0] addr_d [0:3];

    spi_frame_slave #(.READ_LAT(READ_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .SPI_CS       (SPI_CS),
        .SPI_CLK      (SPI_CLK),
        .SPI_SI       (SPI_SI),
        .SPI_SO       (SPI_SO),
        .SERIAL_data  (SERIAL_data),
        .SERIAL_addr  (SERIAL_addr),
        .SERIAL_valid (SERIAL_valid),
        .SPI_data_i   (SPI_data_i),
        .o_dbg_state  (o_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents as a pure function of address
    function automatic logic [31:0] ram_word(input logic [15:0] a);
        if (a == 16'h0010) return 32'hCAFEF00D;
        return {a ^ 16'h5A3C, ~a + 16'd7};
    endfunction

    // RAM port model: data for an address is valid READ_LAT clocks after it is driven
    always @(posedge clk) begin
        addr_d[0] <= SERIAL_addr;
        for (int i = 1; i < 4; i++) addr_d[i] <= addr_d[i-1];
    end
    assign SPI_data_i = (READ_LAT == 1) ? ram_word(SERIAL_addr) : ram_word(addr_d[LAT_IDX]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-strobe monitor
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (SERIAL_valid) begin
            logic [47:0] e;
            check("strobe_width", {63'd0, prev_valid}, 64'd0);
            check("strobe_cs_low", {63'd0, SPI_CS}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {16'd0, SERIAL_addr, SERIAL_data}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {48'd0, SERIAL_addr}, {48'd0, e[47:32]});
                check("wr_data", {32'd0, SERIAL_data}, {32'd0, e[31:0]});
            end
        end
        prev_valid = SERIAL_valid;
    end

    // Read-word monitor
    always @(negedge clk) begin
        if (rd_obs_q.size() != 0) begin
            logic [31:0] o;
            o = rd_obs_q.pop_front();
            if (rd_exp_q.size() == 0) begin
                check("unexpected_read_word", {32'd0, o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("read_word", {32'd0, o}, {32'd0, rd_exp_q.pop_front()});
            end
        end
    end

    // Reference model: what a frame of nbits data bits must produce
    task automatic expect_frame(input logic [7:0] cmd, input logic [15:0] addr, input int nbits);
        int full;
        logic [15:0] a;
        full = nbits / 32;
        for (int k = 0; k < full; k++) begin
            a = addr + 16'(k);
            if (cmd[7]) begin
                if (BURST || k == 0) exp_q.push_back({a, wdata[k]});
            end else begin
                if (BURST) rd_exp_q.push_back(ram_word(a));
                else       rd_exp_q.push_back((k == 0) ? ram_word(addr) : 32'd0);
            end
        end
    endtask

    // One SCK period: SI set while low, SO sampled just before the rise
    task automatic sck_bit(input logic si, output logic so);
        SPI_SI = si;
        repeat (HALF) @(negedge clk);
        so = SPI_SO;
        SPI_CLK = 1'b1;
        repeat (HALF) @(negedge clk);
        SPI_CLK = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic so;
        for (int i = n - 1; i >= 0; i--) sck_bit(v[i], so);
    endtask

    // Full frame: cmd, addr, then nbits of data from wdata[]; ends with CS high
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input int nbits);
        logic so;
        logic [31:0] acc;
        acc = 32'd0;
        SPI_CS = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits({24'd0, cmd}, 8);
        send_bits({16'd0, addr}, 16);
        for (int b = 0; b < nbits; b++) begin
            sck_bit(wdata[b / 32][31 - (b % 32)], so);
            acc = {acc[30:0], so};
            if ((b % 32 == 31) && !cmd[7]) rd_obs_q.push_back(acc);
        end
        repeat (HALF) @(negedge clk);
        SPI_CS = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_cs", {61'd0, o_dbg_state}, 64'd0);
        check("so_after_cs", {63'd0, SPI_SO}, 64'd0);
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] cmd, input logic [15:0] addr, input int nbits);
        expect_frame(cmd, addr, nbits);
        run_frame(cmd, addr, nbits);
    endtask

    // Global watchdog
    initial begin
        repeat (90000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [7:0]  cmd;
        logic [15:0] addr;
        int nbits;

        SPI_CS  = 1'b1;
        SPI_CLK = 1'b0;
        SPI_SI  = 1'b0;
        reset   = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_so",    {63'd0, SPI_SO}, 64'd0);
        check("rst_data",  {32'd0, SERIAL_data}, 64'd0);
        check("rst_addr",  {48'd0, SERIAL_addr}, 64'd0);
        check("rst_valid", {63'd0, SERIAL_valid}, 64'd0);
        check("rst_state", {61'd0, o_dbg_state}, 64'd0);

        // Reset in the middle of the address phase; nothing may come of it
        SPI_CS = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(32'h80, 8);
        send_bits(32'h00, 8);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midframe_reset_state", {61'd0, o_dbg_state}, 64'd0);
        send_bits(32'h0F, 8);
        SPI_CS = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("midframe_reset_addr", {48'd0, SERIAL_addr}, 64'd0);

        wdata[0] = 32'h12345678;
        issue(8'h80, 16'h0042, 32);

        wdata[0] = 32'hDEADBEEF;
        issue(8'h80, 16'h00A5, 32);

        wdata[0] = $urandom;
        issue(8'h00, 16'h0010, 32);

        wdata[0] = 32'd1; wdata[1] = 32'd2; wdata[2] = 32'd3;
        issue(8'h80, 16'hFFFF, 96);

        // Write cut after 20 data bits: no strobe, next frame clean
        wdata[0] = 32'hA5A5_0F0F;
        issue(8'h80, 16'h1234, 20);
        wdata[0] = 32'h0BAD_F00D;
        issue(8'hFF, 16'h1235, 32);

        // Read across the address wrap
        wdata[0] = $urandom; wdata[1] = $urandom; wdata[2] = $urandom;
        issue(8'h7F, 16'hFFFE, 96);

        // Randomized frames
        for (int n = 0; n < 12; n++) begin
            cmd  = 8'($urandom);
            addr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) addr = 16'hFFFE + 16'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) nbits = $urandom_range(1, 63);
            else                           nbits = 32 * $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) wdata[k] = $urandom;
            issue(cmd, addr, nbits);
        end

        // Let monitors drain, bounded
        for (int i = 0; i < 200 && (exp_q.size() != 0 || rd_obs_q.size() != 0); i++) @(negedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        check("pending_reads", 64'(rd_exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
